// File: rtl/tz_pkg.sv
// Shared types and helpers for the TrustZone read-response path.
//   tz_rsp_t      : one staged response, security tag plus 32-bit data
//   TZ_SEC        : tag value meaning secure
//   TZ_NONSEC     : tag value meaning non-secure
//   tz_in_window  : inclusive address-window test (addresses zero-extended to 64 bits)
package tz_pkg;

    typedef struct packed {
        logic        sec;
        logic [31:0] data;
    } tz_rsp_t;

    localparam logic TZ_SEC    = 1'b1;
    localparam logic TZ_NONSEC = 1'b0;

    function automatic logic tz_in_window(input logic [63:0] addr,
                                          input logic [63:0] base,
                                          input logic [63:0] limit);
        return (addr >= base) && (addr <= limit);
    endfunction

endpackage

// File: rtl/tz_sync_fifo.sv
// Synchronous first-word-fall-through FIFO used as response storage.
// Ports:
//   clk    in   clock, all state on posedge
//   rst    in   synchronous active-high reset (pointers and count cleared)
//   push   in   write wdata this cycle (ignored while full)
//   pop    in   advance the head this cycle (ignored while empty)
//   wdata  in   WIDTH-bit entry to write
//   rdata  out  current head entry (undefined content while empty)
//   full   out  count == DEPTH, from registered count
//   empty  out  count == 0, from registered count
module tz_sync_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            // DEPTH is a power of two, so natural overflow wraps the pointer
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; a zero count hides stale entries.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/tz_rsp_queue.sv
// Read-response staging queue between the memory fabric and the TrustZone peripheral.
// Responses are tagged on entry (upstream tag OR secure address window), queued, and
// presented first-word-fall-through. The memory side cannot be stalled: a response
// arriving while full is dropped and counted.
// Optional feature macro: TZ_RSP_PARITY_EN adds an even-parity bit per entry; a head
// mismatch forces the fail-secure output (rdata=0, sec=1) and sets overflow.
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   mem_rvalid/raddr/     incoming response (no backpressure)
//   rdata/rsec
//   rvalid, rready        head handshake toward the peripheral
//   rdata,                head data and security tag (0 / 1 while empty)
//   rdata_security_level
//   full                  queue holds DEPTH entries
//   drop_cnt              saturating count of dropped responses
//   overflow              sticky drop/parity-error flag, cleared only by rst
module tz_rsp_queue
    import tz_pkg::*;
#(
    parameter int unsigned   DEPTH     = 4,
    parameter int unsigned   AW        = 32,
    parameter logic [AW-1:0] SEC_BASE  = 32'h0000_A000,
    parameter logic [AW-1:0] SEC_LIMIT = 32'h0000_AFFF,
    parameter int unsigned   CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_rvalid,
    input  logic [AW-1:0]    mem_raddr,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_rsec,
    output logic             rvalid,
    input  logic             rready,
    output logic [31:0]      rdata,
    output logic             rdata_security_level,
    output logic             full,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             overflow
);

    localparam int unsigned RW = $bits(tz_rsp_t);
`ifdef TZ_RSP_PARITY_EN
    localparam int unsigned EW = RW + 1;
`else
    localparam int unsigned EW = RW;
`endif

    tz_rsp_t          push_rsp;
    tz_rsp_t          head_rsp;
    logic [EW-1:0]    fifo_wdata;
    logic [EW-1:0]    fifo_rdata;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;
    logic             drop;
    logic             head_err;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic             overflow_q, overflow_d;

    // Tag can only be upgraded to secure, never cleared.
    always_comb begin
        push_rsp.sec  = mem_rsec |
                        tz_in_window(64'(mem_raddr), 64'(SEC_BASE), 64'(SEC_LIMIT));
        push_rsp.data = mem_rdata;
    end

`ifdef TZ_RSP_PARITY_EN
    // Even parity: stored bit makes the XOR over the whole entry zero.
    assign fifo_wdata = {^push_rsp, push_rsp};
    assign head_err   = ^fifo_rdata;
`else
    assign fifo_wdata = push_rsp;
    assign head_err   = 1'b0;
`endif
    assign head_rsp   = fifo_rdata[RW-1:0];

    assign fifo_push = mem_rvalid && !full;
    assign fifo_pop  = rvalid && rready;
    assign drop      = mem_rvalid && full;

    tz_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .full  (full),
        .empty (fifo_empty)
    );

    assign rvalid = !fifo_empty;

    // Idle or corrupted head presents the fail-secure value.
    always_comb begin
        rdata                = '0;
        rdata_security_level = TZ_SEC;
        if (rvalid && !head_err) begin
            rdata                = head_rsp.data;
            rdata_security_level = head_rsp.sec;
        end
    end

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
        overflow_d = overflow_q | drop | (rvalid && head_err);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_tz_rsp_queue.sv
// Self-checking bench for tz_rsp_queue: directed scenarios followed by randomized
// traffic, all compared against a queue-based reference model.
module tb_tz_rsp_queue;

    localparam int unsigned DEPTH   = 4;
    localparam int          CNT_MAX = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_raddr = '0;
    logic [31:0] mem_rdata = '0;
    logic        mem_rsec = 1'b0;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [31:0] rdata;
    logic        rdata_security_level;
    logic        full;
    logic [7:0]  drop_cnt;
    logic        overflow;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [32:0] mq[$];
    int          m_drops = 0;
    logic        m_ovf   = 1'b0;

    logic [31:0] addrs[5];

    tz_rsp_queue dut (
        .clk                  (clk),
        .rst                  (rst),
        .mem_rvalid           (mem_rvalid),
        .mem_raddr            (mem_raddr),
        .mem_rdata            (mem_rdata),
        .mem_rsec             (mem_rsec),
        .rvalid               (rvalid),
        .rready               (rready),
        .rdata                (rdata),
        .rdata_security_level (rdata_security_level),
        .full                 (full),
        .drop_cnt             (drop_cnt),
        .overflow             (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic in_win(input logic [31:0] a);
        return (a >= 32'h0000_A000) && (a <= 32'h0000_AFFF);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("rvalid", 32'(rvalid), 32'(mq.size() != 0));
        chk("rdata", rdata, (mq.size() != 0) ? mq[0][31:0] : 32'h0);
        chk("rsec", 32'(rdata_security_level), (mq.size() != 0) ? 32'(mq[0][32]) : 32'h1);
        chk("full", 32'(full), 32'(mq.size() == DEPTH));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drops));
        chk("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    // Drive one cycle, advance the model at the edge, check 1 time unit later.
    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] d,
                        input logic s, input logic rr, input logic r);
        int sz;
        rst        = r;
        mem_rvalid = v;
        mem_raddr  = a;
        mem_rdata  = d;
        mem_rsec   = s;
        rready     = rr;
        @(posedge clk);
        if (r) begin
            mq.delete();
            m_drops = 0;
            m_ovf   = 1'b0;
        end else begin
            sz = mq.size();
            if (rr && sz != 0) void'(mq.pop_front());
            if (v && sz < DEPTH) begin
                mq.push_back({s | in_win(a), d});
            end else if (v) begin
                if (m_drops < CNT_MAX) m_drops++;
                m_ovf = 1'b1;
            end
        end
        #1;
        check_model();
    endtask

    initial begin
        logic [31:0] d;
        addrs[0] = 32'h0000_A000;
        addrs[1] = 32'h0000_AFFF;
        addrs[2] = 32'h0000_9FFF;
        addrs[3] = 32'h0000_B000;
        addrs[4] = 32'h1234_5678;

        // 1. Reset held two cycles with a response present
        step(1'b1, 32'hA010, 32'hdead_beef, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'hA010, 32'hdead_beef, 1'b0, 1'b0, 1'b1);
        chk("t1_rvalid", 32'(rvalid), 32'h0);
        chk("t1_rdata", rdata, 32'h0);
        chk("t1_rsec", 32'(rdata_security_level), 32'h1);
        chk("t1_full", 32'(full), 32'h0);
        chk("t1_drop", 32'(drop_cnt), 32'h0);

        // 2. Window tagging
        step(1'b1, 32'h0000_A010, 32'ha3b1_a010, 1'b0, 1'b0, 1'b0);
        chk("t2_head0_data", rdata, 32'ha3b1_a010);
        chk("t2_head0_sec", 32'(rdata_security_level), 32'h1);
        step(1'b1, 32'h0000_0010, 32'd10, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("t2_head1_data", rdata, 32'd10);
        chk("t2_head1_sec", 32'(rdata_security_level), 32'h0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);

        // 3. Fill and drop
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 32'h0000_0100, 32'h3000 + i, 1'b0, 1'b0, 1'b0);
            if (i == 3) chk("t3_full_after4", 32'(full), 32'h1);
        end
        chk("t3_drop", 32'(drop_cnt), 32'd2);
        chk("t3_ovf", 32'(overflow), 32'h1);
        for (int i = 0; i < 4; i++) begin
            chk("t3_order", rdata, 32'h3000 + i);
            step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        end

        // 4. Concurrent push/pop at count 2 across pointer wrap
        step(1'b1, 32'h0000_A100, 32'h4000, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h0000_0200, 32'h4001, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, addrs[i % 5], 32'h4002 + i, 1'(i), 1'b1, 1'b0);
            chk("t4_count", 32'(dut.u_fifo.count_q), 32'd2);
        end
        chk("t4_nodrop", 32'(drop_cnt), 32'd2);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);

        // 5. Mid-stream reset
        for (int i = 0; i < 3; i++) step(1'b1, 32'h0, 32'h5000 + i, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
        chk("t5_rvalid", 32'(rvalid), 32'h0);
        chk("t5_count", 32'(dut.u_fifo.count_q), 32'h0);
        step(1'b1, 32'h0, 32'd7, 1'b0, 1'b0, 1'b0);
        chk("t5_data", rdata, 32'd7);
        chk("t5_sec", 32'(rdata_security_level), 32'h0);

        // Drop counter saturation
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 264; i++) step(1'b1, 32'h0, 32'(i), 1'b0, 1'b0, 1'b0);
        chk("sat_drop", 32'(drop_cnt), 32'd255);

        // Randomized traffic
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 400; i++) begin
            d = $urandom;
            step(1'($urandom_range(0, 3) != 0), addrs[$urandom_range(0, 4)], d,
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 79) == 0));
        end

`ifdef TZ_RSP_PARITY_EN
        // 6. Corrupt a stored bit; head must go fail-secure and flag overflow
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h0, 32'h0000_0005, 1'b0, 1'b0, 1'b0);
        dut.u_fifo.mem_q[0][0] = ~dut.u_fifo.mem_q[0][0];
        #1;
        chk("t6_rdata", rdata, 32'h0);
        chk("t6_rsec", 32'(rdata_security_level), 32'h1);
        mem_rvalid = 1'b0;
        rready     = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_ovf", 32'(overflow), 32'h1);
        chk("t6_popped", 32'(rvalid), 32'h0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
